// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 display sequencer: register addresses,
// sequencer state encoding and the power-up configuration word table.
package max7219_pkg;

    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCAN      = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam int unsigned INIT_WORDS  = 5;
    localparam logic [3:0]  CODEB_BLANK = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_WAIT,
        ST_FETCH,
        ST_SEND
    } seq_state_t;

    // Configuration words in transmit order: test off, code-B, scan, intensity, run.
    function automatic logic [15:0] init_word(
        input logic [2:0] idx,
        input logic [3:0] scan_limit,
        input logic [3:0] intensity
    );
        logic [15:0] w;
        case (idx)
            3'd0:    w = {4'h0, REG_TEST,      8'h00};
            3'd1:    w = {4'h0, REG_DECODE,    8'hFF};
            3'd2:    w = {4'h0, REG_SCAN,      4'h0, scan_limit};
            3'd3:    w = {4'h0, REG_INTENSITY, 4'h0, intensity};
            default: w = {4'h0, REG_SHUTDOWN,  8'h01};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_shift.sv
// MAX7219 serial word shifter: 16 bits MSB first, SCLK_DIV cycles per clock
// half period, LOAD low for the whole word and held high for one half period after.
module max7219_shift #(
    parameter int unsigned SCLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [15:0] i_word,
    output logic        o_done,
    output logic        o_serial_data,
    output logic        o_serial_clk,
    output logic        o_serial_load
);

    localparam logic [7:0] DIV_LAST  = 8'(SCLK_DIV - 1);
    localparam logic [5:0] PH_LAST   = 6'd31;
    localparam logic [5:0] PH_HOLD   = 6'd32;

    logic        r_busy;
    logic        r_done;
    logic        r_data;
    logic        r_sclk;
    logic        r_load;
    logic [14:0] r_sreg;
    logic [7:0]  r_div;
    logic [5:0]  r_phase;

    // Even phases are clock-low halves, odd phases clock-high; phase 32 is the load-high hold.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= 1'b0;
            r_sclk  <= 1'b0;
            r_load  <= 1'b1;
            r_sreg  <= '0;
            r_div   <= '0;
            r_phase <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_busy  <= 1'b1;
                    r_load  <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_data  <= i_word[15];
                    r_sreg  <= i_word[14:0];
                    r_div   <= '0;
                    r_phase <= '0;
                end
            end else if (r_div != DIV_LAST) begin
                r_div <= r_div + 8'd1;
            end else begin
                r_div   <= '0;
                r_phase <= r_phase + 6'd1;
                if (r_phase == PH_HOLD) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else if (r_phase == PH_LAST) begin
                    r_sclk <= 1'b0;
                    r_data <= 1'b0;
                    r_load <= 1'b1;
                end else if (!r_phase[0]) begin
                    r_sclk <= 1'b1;
                end else begin
                    r_sclk <= 1'b0;
                    r_data <= r_sreg[14];
                    r_sreg <= {r_sreg[13:0], 1'b0};
                end
            end
        end
    end

    assign o_done        = r_done;
    assign o_serial_data = r_data;
    assign o_serial_clk  = r_sclk;
    assign o_serial_load = r_load;

endmodule

// File: rtl/max7219_sequencer.sv
// MAX7219 display sequencer: configures the driver once after enable, then sends
// one digit-register write per digit on each refresh strobe.
// Define SEQ_BLANK_ZERO_EN to blank a zero in the most significant digit.
module max7219_sequencer
    import max7219_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCLK_DIV   = 4,
    parameter logic [3:0]  INTENSITY  = 4'h8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic       i_refresh_stb,
    output logic [2:0] o_digit_sel,
    input  logic [3:0] i_digit_bcd,
    input  logic       i_digit_dp,
    output logic       o_busy,
    output logic       o_serial_data,
    output logic       o_serial_load,
    output logic       o_serial_clk
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_DIGITS - 1);
    localparam logic [3:0] NUM_IDX   = 4'(NUM_DIGITS);
    localparam logic [2:0] INIT_LAST = 3'(INIT_WORDS - 1);

    seq_state_t  r_state;
    logic [2:0]  r_init_idx;
    logic [3:0]  r_idx;
    logic        r_fetch_cnt;
    logic        r_pending;
    logic        r_start;
    logic        r_busy;
    logic [2:0]  r_digit_sel;
    logic [15:0] r_word;

    logic        w_done;
    logic [3:0]  w_idx_next;
    logic [3:0]  w_data_lo;

    always_comb begin
        w_idx_next = r_idx + 4'd1;
        w_data_lo  = i_digit_bcd;
`ifdef SEQ_BLANK_ZERO_EN
        if (r_idx == LAST_IDX && i_digit_bcd == 4'h0) begin
            w_data_lo = CODEB_BLANK;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_init_idx  <= '0;
            r_idx       <= '0;
            r_fetch_cnt <= 1'b0;
            r_pending   <= 1'b0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_digit_sel <= '0;
            r_word      <= '0;
        end else begin
            r_start <= 1'b0;
            if (i_refresh_stb && r_state != ST_IDLE) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_pending <= 1'b0;
                    if (i_en) begin
                        r_state    <= ST_INIT;
                        r_busy     <= 1'b1;
                        r_init_idx <= '0;
                        r_word     <= init_word(3'd0, LAST_IDX, INTENSITY);
                        r_start    <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (w_done) begin
                        if (!i_en) begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_pending <= 1'b0;
                        end else if (r_init_idx == INIT_LAST) begin
                            r_state <= ST_WAIT;
                            r_busy  <= 1'b0;
                        end else begin
                            r_init_idx <= r_init_idx + 3'd1;
                            r_word     <= init_word(r_init_idx + 3'd1, LAST_IDX, INTENSITY);
                            r_start    <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_en) begin
                        r_state   <= ST_IDLE;
                        r_pending <= 1'b0;
                    end else if (r_pending) begin
                        // A strobe landing in this very cycle becomes the next pending frame.
                        r_pending   <= i_refresh_stb;
                        r_idx       <= '0;
                        r_digit_sel <= '0;
                        r_fetch_cnt <= 1'b0;
                        r_state     <= ST_FETCH;
                        r_busy      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (!i_en) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_pending <= 1'b0;
                    end else if (!r_fetch_cnt) begin
                        r_fetch_cnt <= 1'b1;
                    end else begin
                        r_word  <= {4'h0, w_idx_next, i_digit_dp, 3'b000, w_data_lo};
                        r_start <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_done) begin
                        r_idx <= w_idx_next;
                        if (!i_en) begin
                            r_state   <= ST_IDLE;
                            r_busy    <= 1'b0;
                            r_pending <= 1'b0;
                        end else if (w_idx_next == NUM_IDX) begin
                            r_state <= ST_WAIT;
                            r_busy  <= 1'b0;
                        end else begin
                            r_digit_sel <= w_idx_next[2:0];
                            r_fetch_cnt <= 1'b0;
                            r_state     <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    max7219_shift #(
        .SCLK_DIV(SCLK_DIV)
    ) u_shift (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_start       (r_start),
        .i_word        (r_word),
        .o_done        (w_done),
        .o_serial_data (o_serial_data),
        .o_serial_clk  (o_serial_clk),
        .o_serial_load (o_serial_load)
    );

    assign o_digit_sel = r_digit_sel;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_max7219_sequencer.sv
// Directed bench for max7219_sequencer: decodes MAX7219 words from the serial pins
// and compares them with hand-computed register writes.
module tb_max7219_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en;
    logic       stb;
    logic [2:0] sel;
    logic [3:0] digit_bcd = 4'h0;
    logic       digit_dp = 1'b0;
    logic       busy;
    logic       sdata;
    logic       sload;
    logic       sclk;

    logic [3:0] tb_bcd [8];
    logic       tb_dp  [8];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [15:0] mon_words[$];
    int unsigned mon_bits[$];
    int unsigned mon_len[$];
    int unsigned cyc = 0;
    int unsigned low_start = 0;
    int unsigned cur_bits = 0;
    logic [15:0] cur_word = '0;
    logic        prev_sclk = 1'b0;
    logic        prev_load = 1'b1;

    max7219_sequencer #(
        .NUM_DIGITS(6),
        .SCLK_DIV  (4),
        .INTENSITY (4'h8)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_en          (en),
        .i_refresh_stb (stb),
        .o_digit_sel   (sel),
        .i_digit_bcd   (digit_bcd),
        .i_digit_dp    (digit_dp),
        .o_busy        (busy),
        .o_serial_data (sdata),
        .o_serial_load (sload),
        .o_serial_clk  (sclk)
    );

    always #5 clk = ~clk;

    // Registered digit selector upstream of the sequencer (one-cycle latency).
    always @(posedge clk) begin
        digit_bcd <= tb_bcd[sel];
        digit_dp  <= tb_dp[sel];
    end

    // Serial pin decoder, sampled on the falling system-clock edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (prev_load && !sload) begin
            cur_bits  = 0;
            cur_word  = '0;
            low_start = cyc;
        end
        if (!prev_sclk && sclk && !sload) begin
            cur_word = {cur_word[14:0], sdata};
            cur_bits = cur_bits + 1;
        end
        if (!prev_load && sload) begin
            mon_words.push_back(cur_word);
            mon_bits.push_back(cur_bits);
            mon_len.push_back(cyc - low_start);
        end
        prev_sclk = sclk;
        prev_load = sload;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_words(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned i = 0;
        while (mon_words.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(mon_words.size()), 32'(n));
    endtask

    task automatic wait_idle(input int unsigned budget, input string tag);
        int unsigned i = 0;
        while (busy !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_bits(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned i = 0;
        while (!(sload == 1'b0 && cur_bits == n) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(cur_bits), 32'(n));
    endtask

    task automatic pulse_stb();
        @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
    endtask

    task automatic check_init(input string tag, input logic timing);
        logic [15:0] exp_init [5];
        exp_init[0] = 16'h0F00;
        exp_init[1] = 16'h09FF;
        exp_init[2] = 16'h0B05;
        exp_init[3] = 16'h0A08;
        exp_init[4] = 16'h0C01;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("%s_w%0d", tag, i), 32'(mon_words[i]), 32'(exp_init[i]));
            if (timing) begin
                check($sformatf("%s_bits%0d", tag, i), 32'(mon_bits[i]), 32'd16);
                check($sformatf("%s_len%0d", tag, i), 32'(mon_len[i]), 32'd128);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int unsigned off, input logic [15:0] w0,
                               input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3,
                               input logic [15:0] w4, input logic [15:0] w5);
        logic [15:0] exp_f [6];
        exp_f[0] = w0; exp_f[1] = w1; exp_f[2] = w2;
        exp_f[3] = w3; exp_f[4] = w4; exp_f[5] = w5;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s_w%0d", tag, i), 32'(mon_words[off + i]), 32'(exp_f[i]));
        end
    endtask

    task automatic set_time_123456();
        for (int i = 0; i < 8; i++) begin
            tb_bcd[i] = 4'h0;
            tb_dp[i]  = 1'b0;
        end
        tb_bcd[0] = 4'd6; tb_bcd[1] = 4'd5; tb_bcd[2] = 4'd4;
        tb_bcd[3] = 4'd3; tb_bcd[4] = 4'd2; tb_bcd[5] = 4'd1;
        tb_dp[2]  = 1'b1;
    endtask

    initial begin
        logic [15:0]  exp_hours_tens;
        int unsigned  n0;

        en  = 1'b0;
        stb = 1'b0;
        set_time_123456();

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_load", 32'(sload), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_data", 32'(sdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel",  32'(sel), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Configuration sequence after enable.
        @(negedge clk) en = 1'b1;
        wait_words(5, 1500, "init_count");
        check_init("init", 1'b1);
        wait_idle(200, "init_idle");
        check("init_sclk_idle", 32'(sclk), 32'd0);
        check("init_load_idle", 32'(sload), 32'd1);

        // Time 12:34:56 with a decimal point on digit index 2.
        mon_words.delete(); mon_bits.delete(); mon_len.delete();
        pulse_stb();
        wait_words(6, 2000, "frame_count");
        check_frame("frame", 0, 16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0502, 16'h0601);
        wait_idle(200, "frame_idle");
        check("sel_hold", 32'(sel), 32'd5);

        // Hours 09 and a code-B value above 9 on digit 0.
        tb_bcd[0] = 4'hA; tb_bcd[1] = 4'd5; tb_bcd[2] = 4'd4;
        tb_bcd[3] = 4'd3; tb_bcd[4] = 4'd9; tb_bcd[5] = 4'd0;
        tb_dp[2]  = 1'b0;
`ifdef SEQ_BLANK_ZERO_EN
        exp_hours_tens = 16'h060F;
`else
        exp_hours_tens = 16'h0600;
`endif
        mon_words.delete(); mon_bits.delete(); mon_len.delete();
        pulse_stb();
        wait_words(6, 2000, "blank_count");
        check_frame("blank", 0, 16'h010A, 16'h0205, 16'h0304, 16'h0403, 16'h0509, exp_hours_tens);
        wait_idle(200, "blank_idle");

        // Several strobes during one frame collapse into a single extra frame.
        set_time_123456();
        mon_words.delete(); mon_bits.delete(); mon_len.delete();
        pulse_stb();
        repeat (50) @(negedge clk);
        pulse_stb();
        repeat (100) @(negedge clk);
        pulse_stb();
        repeat (100) @(negedge clk);
        pulse_stb();
        wait_words(12, 4000, "collapse_count");
        wait_idle(300, "collapse_idle");
        repeat (400) @(negedge clk);
        check("collapse_total", 32'(mon_words.size()), 32'd12);
        check_frame("collapse2", 6, 16'h0106, 16'h0205, 16'h0384, 16'h0403, 16'h0502, 16'h0601);
        check("collapse_busy", 32'(busy), 32'd0);

        // Disable in the middle of a word: the word still completes.
        mon_words.delete(); mon_bits.delete(); mon_len.delete();
        pulse_stb();
        wait_bits(8, 400, "dis_reach_bit7");
        en = 1'b0;
        wait_words(1, 400, "dis_count");
        check("dis_bits", 32'(mon_bits[0]), 32'd16);
        check("dis_word", 32'(mon_words[0]), 32'h0106);
        wait_idle(200, "dis_idle");
        pulse_stb();
        repeat (400) @(negedge clk);
        check("dis_no_more", 32'(mon_words.size()), 32'd1);

        // Re-enable repeats configuration and the strobe seen while idle is dropped.
        mon_words.delete(); mon_bits.delete(); mon_len.delete();
        en = 1'b1;
        wait_words(5, 1500, "reinit_count");
        check_init("reinit", 1'b0);
        wait_idle(200, "reinit_idle");
        repeat (400) @(negedge clk);
        check("reinit_no_frame", 32'(mon_words.size()), 32'd5);

        // Reset in the middle of a word aborts it at once.
        mon_words.delete(); mon_bits.delete(); mon_len.delete();
        pulse_stb();
        wait_bits(5, 400, "rst_reach_bit");
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("abort_load", 32'(sload), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_data", 32'(sdata), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        n0 = mon_words.size();
        check("abort_edges", 32'(n0), 32'd1);
        check("abort_partial", 32'(mon_bits[0] < 16), 32'd1);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        check("abort_no_more", 32'(mon_words.size()), 32'(n0));
        check("abort_busy_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
